wino_tile_scheduler: RTL and testbench
======================================

Name: wino_tile_scheduler

Overview:
- Sequences one Winograd convolution layer through the PE chain.
- Walks output depth (OD), then input depth (ID), then 6x6 input tiles in raster order.
- Per (OD, ID) pair: issues one weight-tile request, then streams input-tile index windows into the first PE over valid/ready handshakes.
- Layer configuration is latched on start; a one-cycle done pulse follows the last tile.

Parameters:
- IDX_W, 9, height/width index width (max dimension 511)
- OD_W, 8, output-depth counter width
- ID_W, 4, input-depth counter width
- TILE_DIM, 6, input tile edge in elements

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin layer; sampled only in IDLE
- cfg_size_type  in  1  0 = 1x1 kernel (tile stride 6); 1 = 3x3 kernel (tile stride 4)
- cfg_total_height  in  IDX_W  feature-map height
- cfg_total_width  in  IDX_W  feature-map width
- cfg_num_od  in  OD_W  number of output channels
- cfg_num_id  in  ID_W  number of input channels
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at layer completion
- w_valid  out  1  weight-tile request valid
- w_ready  in  1  weight loader accepts request
- w_od  out  OD_W  requested weight OD
- w_id  out  ID_W  requested weight ID
- size_type  out  1  latched cfg_size_type, drives the PE size_type input
- in_valid  out  1  input-tile request valid
- in_ready  in  1  PE chain accepts tile
- in_low_height_index  out  IDX_W  first row of window
- in_high_height_index  out  IDX_W  last row of window, clipped
- in_low_width_index  out  IDX_W  first column of window
- in_high_width_index  out  IDX_W  last column of window, clipped
- in_pad  out  1  window clipped at bottom or right edge
- in_od  out  OD_W  current OD
- in_id  out  ID_W  current ID
- in_first_id  out  1  in_id==0; downstream clears its accumulator
- in_last_id  out  1  in_id==num_id-1; downstream writes back its result
- in_last_tile  out  1  last tile of the current (OD, ID) pair

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0. Reset mid-operation aborts immediately to IDLE with no done pulse.
- Clock/reset are fixed: one clock; reset is asynchronous and active-high (already decided).
- States:
  - IDLE: on start, latch cfg_* and go to LOAD_W. If any of height, width, num_od or num_id is 0, go to FIN instead.
  - LOAD_W: w_valid=1. On w_valid&&w_ready, go to STREAM.
  - STREAM: in_valid=1. Each in_valid&&in_ready advances the col counter, then the row counter.
    - On the last tile's handshake: if more (OD, ID) pairs remain, go to LOAD_W; else go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Pair order: id increments fastest; wrapping id to 0 increments od.
- Stride S: 4 if size_type=1, else 6.
- Tile counts: rows = ceil(H/S), cols = ceil(W/S). Computed in the latch cycle with shifts and adds; no divider.
- Window limits:
  - low = tile*S
  - high = min(low+5, total-1)
  - in_pad=1 iff either dimension was clipped.
  - Arithmetic is in IDX_W+1 bits before clipping, so there is no wrap at 511.
- Timing: start accepted at edge N gives w_valid=1 in cycle N+1. The weight handshake at edge M gives in_valid=1 in cycle M+1.
- Throughput: tiles stream back-to-back, one per cycle, while in_ready=1.
- Handshake: valid stays high and every payload field stays stable until accepted; valid is never withdrawn. w_valid and in_valid are never high together.
- start while busy is ignored. cfg_* changes after the latch have no effect.
- done and a new start in the same cycle: done completes and the start is ignored; start must be presented again in IDLE.

Decomposition:
- Package wino_pkg:
  - size_type_e enum (SIZE_1X1=0, SIZE_3X3=1)
  - constants STRIDE_1X1=6, STRIDE_3X3=4, TILE_DIM=6
  - typedefs idx_t (IDX_W bits), od_t, id_t
  - sched_state_e
- Sub-module wino_tile_walker: row/col counters, window low/high clipping, pad and last_tile flags. Interface: advance, clear, totals, stride.

Test Plan:
- size_type=1, H=W=8, od=1, id=1 -> 1 weight request, then 4 tiles. Windows (h,w): (0-5,0-5), (0-5,4-7 pad), (4-7 pad,0-5), (4-7,4-7 pad); last_tile on the 4th; done 1 cycle later.
- size_type=0, H=W=12, od=1, id=1 -> 4 tiles: lows 0/6, highs 5/11, in_pad always 0.
- H=W=4, size_type=1, od=2, id=3 -> 6 weight requests in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); in_first_id on id=0; in_last_id on id=2; 6 tiles total.
- in_ready low for 3 cycles mid-stream -> in_valid held and fields unchanged; next tile 1 cycle after the handshake.
- cfg_num_od=0 with start -> no w_valid/in_valid; done in cycle 2. A start during busy is ignored.
- reset asserted during STREAM -> all outputs 0 asynchronously, no done; a fresh start restarts at od=0, id=0, tile (0,0).

Source files
------------

// File: rtl/wino_pkg.sv
// Shared types and constants for the Winograd tile scheduler.
// Stride selection lives here so the walker and the top agree on it.
package wino_pkg;
    localparam int IDX_W      = 9;
    localparam int OD_W       = 8;
    localparam int ID_W       = 4;
    localparam int TILE_DIM   = 6;
    localparam int STRIDE_1X1 = 6;
    localparam int STRIDE_3X3 = 4;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   idx_ext_t;
    typedef logic [OD_W-1:0]  od_t;
    typedef logic [ID_W-1:0]  id_t;

    typedef enum logic {
        SIZE_1X1 = 1'b0,
        SIZE_3X3 = 1'b1
    } size_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_FIN
    } sched_state_e;

    function automatic idx_ext_t stride_of(input size_type_e st);
        return (st == SIZE_3X3) ? idx_ext_t'(STRIDE_3X3) : idx_ext_t'(STRIDE_1X1);
    endfunction
endpackage

// File: rtl/wino_tile_walker.sv
// Raster walk over input tiles: row/col origins, clipped window limits, pad and last-tile flags.
// Window outputs are combinational from the current origin; advance steps on the next edge.
module wino_tile_walker
    import wino_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    input  logic     advance,
    input  idx_t     total_height,
    input  idx_t     total_width,
    input  idx_ext_t stride,
    output idx_t     low_height,
    output idx_t     high_height,
    output idx_t     low_width,
    output idx_t     high_width,
    output logic     pad,
    output logic     last_tile
);
    idx_t     row_low;
    idx_t     col_low;
    idx_ext_t row_next;
    idx_ext_t col_next;
    idx_ext_t h_span;
    idx_ext_t w_span;
    idx_ext_t h_lim;
    idx_ext_t w_lim;
    logic     h_clip;
    logic     w_clip;
    logic     last_row;
    logic     last_col;

    // One extra bit keeps low+5 and low+stride from wrapping near 511.
    always_comb begin
        row_next = {1'b0, row_low} + stride;
        col_next = {1'b0, col_low} + stride;
        h_span   = {1'b0, row_low} + idx_ext_t'(TILE_DIM - 1);
        w_span   = {1'b0, col_low} + idx_ext_t'(TILE_DIM - 1);
        h_lim    = {1'b0, total_height} - idx_ext_t'(1);
        w_lim    = {1'b0, total_width} - idx_ext_t'(1);
        h_clip   = h_span > h_lim;
        w_clip   = w_span > w_lim;
        last_row = row_next >= {1'b0, total_height};
        last_col = col_next >= {1'b0, total_width};
    end

    assign low_height  = row_low;
    assign low_width   = col_low;
    assign high_height = h_clip ? h_lim[IDX_W-1:0] : h_span[IDX_W-1:0];
    assign high_width  = w_clip ? w_lim[IDX_W-1:0] : w_span[IDX_W-1:0];
    assign pad         = h_clip || w_clip;
    assign last_tile   = last_row && last_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_low <= '0;
            col_low <= '0;
        end else if (clear) begin
            row_low <= '0;
            col_low <= '0;
        end else if (advance) begin
            if (last_col) begin
                col_low <= '0;
                row_low <= last_row ? '0 : row_next[IDX_W-1:0];
            end else begin
                col_low <= col_next[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/wino_tile_scheduler.sv
// Sequences one Winograd layer: per (OD, ID) pair one weight request, then all input tiles.
// Payload outputs are forced to zero whenever their valid is low.
module wino_tile_scheduler
    import wino_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cfg_size_type,
    input  logic [IDX_W-1:0] cfg_total_height,
    input  logic [IDX_W-1:0] cfg_total_width,
    input  logic [OD_W-1:0]  cfg_num_od,
    input  logic [ID_W-1:0]  cfg_num_id,
    output logic             busy,
    output logic             done,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [OD_W-1:0]  w_od,
    output logic [ID_W-1:0]  w_id,
    output logic             size_type,
    output logic             in_valid,
    input  logic             in_ready,
    output logic [IDX_W-1:0] in_low_height_index,
    output logic [IDX_W-1:0] in_high_height_index,
    output logic [IDX_W-1:0] in_low_width_index,
    output logic [IDX_W-1:0] in_high_width_index,
    output logic             in_pad,
    output logic [OD_W-1:0]  in_od,
    output logic [ID_W-1:0]  in_id,
    output logic             in_first_id,
    output logic             in_last_id,
    output logic             in_last_tile
);
    sched_state_e state;
    sched_state_e state_nxt;
    size_type_e   size_q;
    idx_t         height_q;
    idx_t         width_q;
    od_t          num_od_q;
    od_t          od_q;
    id_t          num_id_q;
    id_t          id_q;
    logic         cfg_zero;
    logic         last_pair;
    logic         last_id;
    logic         walk_clear;
    logic         walk_adv;
    idx_t         walk_lh;
    idx_t         walk_hh;
    idx_t         walk_lw;
    idx_t         walk_hw;
    logic         walk_pad;
    logic         walk_last;

    assign cfg_zero  = (cfg_total_height == '0) || (cfg_total_width == '0) ||
                       (cfg_num_od == '0) || (cfg_num_id == '0);
    assign last_id   = id_q == (num_id_q - id_t'(1));
    assign last_pair = last_id && (od_q == (num_od_q - od_t'(1)));
    assign walk_adv  = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        w_valid    = 1'b0;
        in_valid   = 1'b0;
        walk_clear = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    walk_clear = 1'b1;
                    state_nxt  = cfg_zero ? S_FIN : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                busy    = 1'b1;
                w_valid = 1'b1;
                if (w_ready) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy     = 1'b1;
                in_valid = 1'b1;
                if (in_ready && walk_last) state_nxt = last_pair ? S_FIN : S_LOAD_W;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pair counters move only on the last tile of a pair; id wraps into od.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size_q   <= SIZE_1X1;
            height_q <= '0;
            width_q  <= '0;
            num_od_q <= '0;
            num_id_q <= '0;
            od_q     <= '0;
            id_q     <= '0;
        end else if (state == S_IDLE && start) begin
            size_q   <= size_type_e'(cfg_size_type);
            height_q <= cfg_total_height;
            width_q  <= cfg_total_width;
            num_od_q <= cfg_num_od;
            num_id_q <= cfg_num_id;
            od_q     <= '0;
            id_q     <= '0;
        end else if (walk_adv && walk_last && !last_pair) begin
            if (last_id) begin
                id_q <= '0;
                od_q <= od_q + od_t'(1);
            end else begin
                id_q <= id_q + id_t'(1);
            end
        end
    end

    wino_tile_walker u_walker (
        .clk          (clk),
        .rst          (reset),
        .clear        (walk_clear),
        .advance      (walk_adv),
        .total_height (height_q),
        .total_width  (width_q),
        .stride       (stride_of(size_q)),
        .low_height   (walk_lh),
        .high_height  (walk_hh),
        .low_width    (walk_lw),
        .high_width   (walk_hw),
        .pad          (walk_pad),
        .last_tile    (walk_last)
    );

    assign size_type            = size_q;
    assign w_od                 = w_valid ? od_q : '0;
    assign w_id                 = w_valid ? id_q : '0;
    assign in_low_height_index  = in_valid ? walk_lh : '0;
    assign in_high_height_index = in_valid ? walk_hh : '0;
    assign in_low_width_index   = in_valid ? walk_lw : '0;
    assign in_high_width_index  = in_valid ? walk_hw : '0;
    assign in_pad               = in_valid && walk_pad;
    assign in_od                = in_valid ? od_q : '0;
    assign in_id                = in_valid ? id_q : '0;
    assign in_first_id          = in_valid && (id_q == '0);
    assign in_last_id           = in_valid && last_id;
    assign in_last_tile         = in_valid && walk_last;
endmodule

// File: tb/tb_wino_tile_scheduler.sv
// Bench for wino_tile_scheduler: directed vector table, reset/abort sequences and randomized layers
// checked against a loop-based transaction model.
module tb_wino_tile_scheduler;
    import wino_pkg::*;

    typedef struct packed {
        logic is_w;
        od_t  od;
        id_t  id;
        idx_t lh;
        idx_t hh;
        idx_t lw;
        idx_t hw;
        logic pad;
        logic first;
        logic last;
        logic last_tile;
    } txn_t;

    typedef struct {
        logic st;
        int   h;
        int   w;
        int   nod;
        int   nid;
        int   exp_w;
        int   exp_t;
        int   exp_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic reset, start, cfg_size_type;
    idx_t cfg_total_height, cfg_total_width;
    od_t  cfg_num_od;
    id_t  cfg_num_id;
    logic busy, done, w_valid, w_ready, size_type, in_valid, in_ready;
    od_t  w_od, in_od;
    id_t  w_id, in_id;
    idx_t in_low_height_index, in_high_height_index, in_low_width_index, in_high_width_index;
    logic in_pad, in_first_id, in_last_id, in_last_tile;

    int   total = 0;
    int   bad = 0;
    txn_t exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    wino_tile_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .cfg_size_type(cfg_size_type),
        .cfg_total_height(cfg_total_height), .cfg_total_width(cfg_total_width),
        .cfg_num_od(cfg_num_od), .cfg_num_id(cfg_num_id), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_od(w_od), .w_id(w_id), .size_type(size_type),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_low_height_index(in_low_height_index), .in_high_height_index(in_high_height_index),
        .in_low_width_index(in_low_width_index), .in_high_width_index(in_high_width_index),
        .in_pad(in_pad), .in_od(in_od), .in_id(in_id), .in_first_id(in_first_id),
        .in_last_id(in_last_id), .in_last_tile(in_last_tile)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic txn_t dut_tile();
        txn_t t;
        t = '0;
        t.od = in_od; t.id = in_id;
        t.lh = in_low_height_index; t.hh = in_high_height_index;
        t.lw = in_low_width_index;  t.hw = in_high_width_index;
        t.pad = in_pad; t.first = in_first_id; t.last = in_last_id; t.last_tile = in_last_tile;
        return t;
    endfunction

    function automatic txn_t dut_w();
        txn_t t;
        t = '0;
        t.is_w = 1'b1; t.od = w_od; t.id = w_id;
        return t;
    endfunction

    function automatic logic [127:0] all_outputs();
        logic [127:0] r;
        r = '0;
        r[68:0] = {busy, done, w_valid, w_od, w_id, size_type, in_valid,
                   in_low_height_index, in_high_height_index, in_low_width_index,
                   in_high_width_index, in_pad, in_od, in_id, in_first_id, in_last_id, in_last_tile};
        return r;
    endfunction

    // Expected transaction stream for a whole layer, straight from the tiling rules.
    task automatic build_model(input logic st, input int h, input int w, input int nod, input int nid);
        int s, rows, cols, lr, lc;
        txn_t t;
        exp_q.delete();
        if (h == 0 || w == 0 || nod == 0 || nid == 0) return;
        s = st ? 4 : 6;
        rows = (h + s - 1) / s;
        cols = (w + s - 1) / s;
        for (int o = 0; o < nod; o++) begin
            for (int i = 0; i < nid; i++) begin
                t = '0; t.is_w = 1'b1; t.od = od_t'(o); t.id = id_t'(i);
                exp_q.push_back(t);
                for (int r = 0; r < rows; r++) begin
                    for (int c = 0; c < cols; c++) begin
                        lr = r * s; lc = c * s;
                        t = '0; t.od = od_t'(o); t.id = id_t'(i);
                        t.lh = idx_t'(lr); t.hh = idx_t'((lr + 5 < h) ? lr + 5 : h - 1);
                        t.lw = idx_t'(lc); t.hw = idx_t'((lc + 5 < w) ? lc + 5 : w - 1);
                        t.pad = (lr + 5 >= h) || (lc + 5 >= w);
                        t.first = (i == 0); t.last = (i == nid - 1);
                        t.last_tile = (r == rows - 1) && (c == cols - 1);
                        exp_q.push_back(t);
                    end
                end
            end
        end
    endtask

    task automatic compare_next(input string tag, input txn_t got);
        txn_t want;
        check({tag, " queue_nonempty"}, 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check({tag, want.is_w ? " weight" : " tile"}, 128'(got), 128'(want));
        end
    endtask

    task automatic run_layer(input string tag, input logic st, input int h, input int w,
                             input int nod, input int nid, input int stall_pct, input bit noisy,
                             output int n_w, output int n_t, output int cyc);
        txn_t held_in, held_w;
        bit   in_stalled, w_stalled, fin, zero;
        build_model(st, h, w, nod, nid);
        zero = (h == 0 || w == 0 || nod == 0 || nid == 0);
        n_w = 0; n_t = 0; cyc = 0; fin = 0; in_stalled = 0; w_stalled = 0;
        held_in = '0; held_w = '0;
        @(negedge clk);
        cfg_size_type = st; cfg_total_height = idx_t'(h); cfg_total_width = idx_t'(w);
        cfg_num_od = od_t'(nod); cfg_num_id = id_t'(nid); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, " first_cycle"}, {busy, w_valid, done}, zero ? 3'b001 : 3'b110);
        if (!zero) check({tag, " size_type"}, size_type, st);
        while (!fin && cyc < 5000) begin
            check({tag, " excl"}, w_valid && in_valid, 1'b0);
            if (in_stalled) check({tag, " in_hold"}, {in_valid, dut_tile()}, {1'b1, held_in});
            if (w_stalled) check({tag, " w_hold"}, {w_valid, dut_w()}, {1'b1, held_w});
            if (done) begin
                fin = 1;
                check({tag, " busy_at_done"}, busy, 1'b0);
            end else begin
                w_ready  = ($urandom_range(99) >= stall_pct);
                in_ready = ($urandom_range(99) >= stall_pct);
                if (noisy) begin
                    start = 1'($urandom_range(1));
                    cfg_size_type = 1'($urandom_range(1));
                    cfg_total_height = idx_t'($urandom_range(511));
                    cfg_total_width = idx_t'($urandom_range(511));
                    cfg_num_od = od_t'($urandom_range(255));
                    cfg_num_id = id_t'($urandom_range(15));
                end
                in_stalled = in_valid && !in_ready; held_in = dut_tile();
                w_stalled = w_valid && !w_ready;    held_w = dut_w();
                if (w_valid && w_ready) begin n_w++; compare_next(tag, dut_w()); end
                if (in_valid && in_ready) begin n_t++; compare_next(tag, dut_tile()); end
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " done_seen"}, fin, 1'b1);
        check({tag, " leftover"}, 128'(exp_q.size()), 128'd0);
        // Start asserted alongside done must be dropped.
        start = noisy; w_ready = 1'b0; in_ready = 1'b0;
        @(negedge clk);
        check({tag, " post_done"}, {done, busy, w_valid, in_valid}, 4'b0);
        start = 1'b0;
        @(negedge clk);
        check({tag, " start_ignored"}, {busy, w_valid, in_valid}, 3'b0);
    endtask

    initial begin
        int nw, nt, cyc;
        vecs[0] = '{1'b1,   8,  8, 1, 1, 1,   4,   6};
        vecs[1] = '{1'b0,  12, 12, 1, 1, 1,   4,   6};
        vecs[2] = '{1'b1,   4,  4, 2, 3, 6,   6,  13};
        vecs[3] = '{1'b0,   1,  1, 1, 1, 1,   1,   3};
        vecs[4] = '{1'b1,   9,  5, 1, 2, 2,  12,  15};
        vecs[5] = '{1'b0,  13,  7, 2, 1, 2,  12,  15};
        vecs[6] = '{1'b1, 511,  4, 1, 1, 1, 128, 130};
        vecs[7] = '{1'b0,   5,  0, 1, 1, 0,   0,   1};

        reset = 1'b1; start = 1'b0; cfg_size_type = 1'b0; cfg_total_height = '0;
        cfg_total_width = '0; cfg_num_od = '0; cfg_num_id = '0; w_ready = 1'b0; in_ready = 1'b0;
        #12;
        check("reset_outputs", all_outputs(), '0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run_layer($sformatf("vec%0d", k), vecs[k].st, vecs[k].h, vecs[k].w,
                      vecs[k].nod, vecs[k].nid, 0, 1'b0, nw, nt, cyc);
            check($sformatf("vec%0d n_w", k), 128'(nw), 128'(vecs[k].exp_w));
            check($sformatf("vec%0d n_t", k), 128'(nt), 128'(vecs[k].exp_t));
            check($sformatf("vec%0d cycles", k), 128'(cyc), 128'(vecs[k].exp_cyc));
        end

        // Abort in the middle of streaming, then restart from scratch.
        @(negedge clk);
        cfg_size_type = 1'b1; cfg_total_height = 9'd8; cfg_total_width = 9'd8;
        cfg_num_od = 8'd2; cfg_num_id = 4'd2; start = 1'b1; w_ready = 1'b1; in_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort in_valid", in_valid, 1'b1);
        #2 reset = 1'b1;
        #1 check("abort async_reset", all_outputs(), '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort no_done", {done, busy}, 2'b0);
        end
        run_layer("restart", 1'b1, 8, 8, 2, 2, 0, 1'b0, nw, nt, cyc);
        check("restart n_t", 128'(nt), 128'd16);

        for (int k = 0; k < 10; k++) begin
            run_layer($sformatf("rnd%0d", k), 1'($urandom_range(1)), $urandom_range(1, 24),
                      $urandom_range(1, 24), $urandom_range(1, 3), $urandom_range(1, 3),
                      40, 1'b1, nw, nt, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
